dmem_responder: RTL and testbench

//  Responder side of the memory-stage data-access interface of the barrel-threaded RV32 core.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_sram_bank.sv | 21 ++
 rtl/dmem_responder.sv | 96 +++++++++
 tb/tb_dmem_responder.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: funct3 codes, access sizes and byte-lane helpers for the data-memory responder
package dmem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;
  function automatic logic [3:0] byte_en(size_e size, logic [1:0] addr);
    return size == SZ_W ? 4'hf : size == SZ_H ? (addr[1] ? 4'hc : 4'h3) : 4'h1 << addr;
  endfunction
  function automatic logic [31:0] load_extend(logic [31:0] word, size_e size, logic uns, logic [1:0] addr);
    logic [7:0] b;
    logic [15:0] h;
    b = word[{addr, 3'b000} +: 8];
    h = addr[1] ? word[31:16] : word[15:0];
    return size == SZ_W ? word : size == SZ_H ? {{16{h[15] & !uns}}, h} : {{24{b[7] & !uns}}, b};
  endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request and response channels between the memory stage and the data-memory responder
interface dmem_responder_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BITS_THREADS = 3
);
  logic req_valid, req_ready, req_we;
  logic [2:0] req_funct3;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [4:0] req_rd;
  logic [BITS_THREADS-1:0] req_tid;
  logic rsp_valid, rsp_ready, rsp_store, rsp_err;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic [4:0] rsp_rd;
  logic [BITS_THREADS-1:0] rsp_tid;
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, req_tid, rsp_ready,
    input req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_tid, rsp_store, rsp_err
  );
  modport slave (
    input req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, req_tid, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_tid, rsp_store, rsp_err
  );
endinterface

// File: rtl/dmem_sram_bank.sv
// dmem_sram_bank: single-port word RAM with byte-write enables and an enable-gated registered read
module dmem_sram_bank #(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  // lane writes and read capture only on enabled cycles, so a stalled consumer keeps its read word
  always_ff @(posedge clk)
    if (en) begin
      for (int i = 0; i < 4; i++)
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      rdata <= mem[addr];
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: two-stage load/store responder on on-chip word RAM; define DMEM_MISALIGN_TRAP_EN to trap misaligned accesses
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_THREADS = 8,
  parameter int BITS_THREADS = $clog2(NUM_THREADS),
  parameter int DEPTH_WORDS = 1024
) (
  input logic clk,
  input logic rst_n,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  logic s2_adv, s1_adv, accept, illegal, misaligned, err;
  logic s1_valid, s1_uns, s1_err, s1_store;
  size_e size, s1_size;
  logic [1:0] off, s1_off;
  logic [4:0] s1_rd;
  logic [BITS_THREADS-1:0] s1_tid;
  logic [3:0] we;
  logic [DATA_WIDTH-1:0] wlanes, rdata;
  logic unused_addr;
  assign s2_adv = !bus.rsp_valid || bus.rsp_ready;
  assign s1_adv = s1_valid && s2_adv;
  assign bus.req_ready = !s1_valid || s2_adv;
  assign accept = bus.req_valid && bus.req_ready;
  assign off = bus.req_addr[1:0];
  assign unused_addr = ^bus.req_addr[ADDRESS_WIDTH-1:AW+2];
  // decode access size and legality, replicate store data across its lanes
  always_comb begin
    size = bus.req_funct3[1] ? SZ_W : bus.req_funct3[0] ? SZ_H : SZ_B;
    illegal = !(bus.req_funct3 inside {F3_B, F3_H, F3_W} ||
                (!bus.req_we && bus.req_funct3 inside {F3_BU, F3_HU}));
`ifdef DMEM_MISALIGN_TRAP_EN
    misaligned = (size == SZ_H && off[0]) || (size == SZ_W && off != 2'b00);
`else
    misaligned = 1'b0;
`endif
    err = illegal || misaligned;
    wlanes = size == SZ_B ? {4{bus.req_wdata[7:0]}} :
             size == SZ_H ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
    we = accept && bus.req_we && !err ? byte_en(size, off) : 4'h0;
  end
  dmem_sram_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank (
    .clk(clk),
    .en(accept),
    .we(we),
    .addr(bus.req_addr[AW+1:2]),
    .wdata(wlanes),
    .rdata(rdata)
  );
  // S1: capture the accepted request's tags on the same edge the RAM is accessed
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_size <= SZ_B;
      s1_uns <= 1'b0;
      s1_off <= 2'b00;
      s1_err <= 1'b0;
      s1_store <= 1'b0;
      s1_rd <= '0;
      s1_tid <= '0;
    end else if (bus.req_ready) begin
      s1_valid <= bus.req_valid;
      if (bus.req_valid) begin
        s1_size <= size;
        s1_uns <= bus.req_funct3[2];
        s1_off <= off;
        s1_err <= err;
        s1_store <= bus.req_we;
        s1_rd <= bus.req_rd;
        s1_tid <= bus.req_tid;
      end
    end
  // S2: extract load data into the response registers, frozen while writeback stalls
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_rd <= '0;
      bus.rsp_tid <= '0;
      bus.rsp_store <= 1'b0;
      bus.rsp_err <= 1'b0;
    end else begin
      if (s2_adv) bus.rsp_valid <= s1_valid;
      if (s1_adv) begin
        bus.rsp_rdata <= s1_err || s1_store ? '0 : load_extend(rdata, s1_size, s1_uns, s1_off);
        bus.rsp_rd <= s1_rd;
        bus.rsp_tid <= s1_tid;
        bus.rsp_store <= s1_store;
        bus.rsp_err <= s1_err;
      end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scenarios plus randomized traffic against a byte-level memory model
module tb_dmem_responder;
  typedef struct packed {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic [2:0]  tid;
    logic        store;
    logic        err;
  } rsp_t;
  logic clk = 0;
  logic rst_n = 1;
  int checks = 0;
  int passed = 0;
  logic [7:0] mem [64];
  rsp_t exp_q[$];
  always #5 clk = ~clk;
  dmem_responder_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .BITS_THREADS(3)) bus ();
  dmem_responder #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .NUM_THREADS(8), .DEPTH_WORDS(1024)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  function automatic rsp_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [4:0] rd, input logic [2:0] tid);
    rsp_t r;
    int n, ea;
    logic [31:0] v;
    r = '{rdata: 32'h0, rd: rd, tid: tid, store: we, err: 1'b0};
    n = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    ea = int'(addr[5:0]);
    r.err = f3 == 3'b011 || f3 >= 3'b110 || (we && f3[2]);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (ea % n != 0) r.err = 1'b1;
`else
    ea -= ea % n;
`endif
    if (!r.err && we)
      for (int i = 0; i < n; i++) mem[ea+i] = wd[8*i +: 8];
    else if (!r.err) begin
      v = 0;
      for (int i = 0; i < n; i++) v |= 32'(mem[ea+i]) << (8*i);
      if (!f3[2] && n < 4 && v[8*n-1]) v |= 32'hffffffff << (8*n);
      r.rdata = v;
    end
    return r;
  endfunction

  task automatic idle();
    bus.req_valid = 0;
    bus.req_we = 0;
    bus.req_funct3 = 0;
    bus.req_addr = 0;
    bus.req_wdata = 0;
    bus.req_rd = 0;
    bus.req_tid = 0;
  endtask

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd, input logic [2:0] tid);
    bus.req_valid = 1;
    bus.req_we = we;
    bus.req_funct3 = f3;
    bus.req_addr = addr;
    bus.req_wdata = wd;
    bus.req_rd = rd;
    bus.req_tid = tid;
  endtask

  // one isolated transaction; lat = edges from presentation until the response is visible, -1 if none
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [4:0] rd, input logic [2:0] tid, output rsp_t r, output int lat);
    bus.rsp_ready = 1;
    drive(we, f3, addr, wd, rd, tid);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready) break;
      lat++;
    end
    @(posedge clk);
    #1 idle();
    lat++;
    for (int i = 0; i < 20 && !bus.rsp_valid; i++) begin
      @(posedge clk);
      #1 lat++;
    end
    if (!bus.rsp_valid) lat = -1;
    r = rsp_t'{bus.rsp_rdata, bus.rsp_rd, bus.rsp_tid, bus.rsp_store, bus.rsp_err};
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    bus.rsp_ready = 0;
    #2 rst_n = 0;
    #1;
    checks++;
    if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_rd, bus.rsp_tid, bus.rsp_store, bus.rsp_err} !== '0)
      $display("FAIL reset_outputs: got valid=%b rdata=%h rd=%0d tid=%0d store=%b err=%b, want all 0",
               bus.rsp_valid, bus.rsp_rdata, bus.rsp_rd, bus.rsp_tid, bus.rsp_store, bus.rsp_err);
    else passed++;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.req_ready);
    else passed++;
  endtask

  task automatic test_back_to_back();
    bus.rsp_ready = 1;
    drive(1, 3'b010, 32'h10, 32'hdeadbeef, 5'd3, 3'd1);
    @(posedge clk);
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1)
      $display("FAIL b2b_early: got valid=%b ready=%b want valid=0 ready=1", bus.rsp_valid, bus.req_ready);
    else passed++;
    drive(0, 3'b010, 32'h10, 32'h0, 5'd7, 3'd2);
    @(posedge clk);
    #1 idle();
    checks++;
    if ({bus.rsp_valid, bus.rsp_store, bus.rsp_err, bus.rsp_rdata, bus.rsp_rd, bus.rsp_tid} !== {3'b110, 32'h0, 5'd3, 3'd1})
      $display("FAIL b2b_store_rsp: got valid=%b store=%b err=%b rdata=%h rd=%0d tid=%0d want 1 1 0 00000000 3 1",
               bus.rsp_valid, bus.rsp_store, bus.rsp_err, bus.rsp_rdata, bus.rsp_rd, bus.rsp_tid);
    else passed++;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.rsp_valid, bus.rsp_store, bus.rsp_err, bus.rsp_rdata, bus.rsp_rd, bus.rsp_tid} !== {3'b100, 32'hdeadbeef, 5'd7, 3'd2})
      $display("FAIL b2b_load_rsp: got valid=%b store=%b err=%b rdata=%h rd=%0d tid=%0d want 1 0 0 deadbeef 7 2",
               bus.rsp_valid, bus.rsp_store, bus.rsp_err, bus.rsp_rdata, bus.rsp_rd, bus.rsp_tid);
    else passed++;
    @(posedge clk);
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0) $display("FAIL b2b_drained: got valid=%b want 0", bus.rsp_valid);
    else passed++;
  endtask

  task automatic test_extend();
    rsp_t r;
    int lat;
    xact(0, 3'b000, 32'h13, 0, 5'd9, 3'd5, r, lat);
    checks++;
    if (r.rdata !== 32'hffffffde || r.err !== 0 || r.rd !== 5'd9 || r.tid !== 3'd5 || lat !== 2)
      $display("FAIL lb_13: got rdata=%h err=%b rd=%0d tid=%0d lat=%0d want ffffffde 0 9 5 2", r.rdata, r.err, r.rd, r.tid, lat);
    else passed++;
    xact(0, 3'b100, 32'h13, 0, 5'd1, 3'd0, r, lat);
    checks++;
    if (r.rdata !== 32'h000000de || r.err !== 0) $display("FAIL lbu_13: got %h err=%b want 000000de 0", r.rdata, r.err);
    else passed++;
    xact(0, 3'b001, 32'h10, 0, 5'd1, 3'd0, r, lat);
    checks++;
    if (r.rdata !== 32'hffffbeef || r.err !== 0) $display("FAIL lh_10: got %h err=%b want ffffbeef 0", r.rdata, r.err);
    else passed++;
    xact(0, 3'b101, 32'h12, 0, 5'd1, 3'd0, r, lat);
    checks++;
    if (r.rdata !== 32'h0000dead || r.err !== 0) $display("FAIL lhu_12: got %h err=%b want 0000dead 0", r.rdata, r.err);
    else passed++;
    xact(0, 3'b010, 32'habc00010, 0, 5'd1, 3'd0, r, lat);
    checks++;
    if (r.rdata !== 32'hdeadbeef) $display("FAIL lw_alias: got %h want deadbeef", r.rdata);
    else passed++;
  endtask

  task automatic test_store_byte();
    rsp_t r;
    int lat;
    xact(1, 3'b000, 32'h11, 32'haaaaaa55, 5'd4, 3'd6, r, lat);
    checks++;
    if (r.store !== 1 || r.rdata !== 32'h0 || r.err !== 0 || r.tid !== 3'd6)
      $display("FAIL sb_rsp: got store=%b rdata=%h err=%b tid=%0d want 1 00000000 0 6", r.store, r.rdata, r.err, r.tid);
    else passed++;
    xact(0, 3'b010, 32'h10, 0, 5'd1, 3'd0, r, lat);
    checks++;
    if (r.rdata !== 32'hdead55ef || r.store !== 0) $display("FAIL sb_readback: got %h store=%b want dead55ef 0", r.rdata, r.store);
    else passed++;
  endtask

  task automatic test_stall();
    int acc = 0;
    logic have = 0, unstable = 0;
    rsp_t held, cur;
    logic [2:0] tids[$];
    logic [4:0] rds[$];
    logic [31:0] datas[$];
    bus.rsp_ready = 0;
    drive(0, 3'b010, 32'h10, 0, 5'd11, 3'd1);
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      cur = rsp_t'{bus.rsp_rdata, bus.rsp_rd, bus.rsp_tid, bus.rsp_store, bus.rsp_err};
      if (c < 5) begin
        if (have && (cur !== held || bus.rsp_valid !== 1'b1)) unstable = 1;
        if (bus.rsp_valid) begin
          have = 1;
          held = cur;
        end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        tids.push_back(bus.rsp_tid);
        rds.push_back(bus.rsp_rd);
        datas.push_back(bus.rsp_rdata);
      end
      if (bus.req_valid && bus.req_ready) acc++;
      if (c == 4) begin
        checks++;
        if (acc !== 2 || bus.req_ready !== 1'b0)
          $display("FAIL stall_accept: got accepted=%0d ready=%b want 2 0", acc, bus.req_ready);
        else passed++;
      end
      @(posedge clk);
      #1 bus.rsp_ready = c >= 4;
      if (acc < 3) drive(0, 3'b010, 32'h10, 0, 5'(11 + acc), 3'(1 + acc));
      else idle();
    end
    checks++;
    if (unstable || !have) $display("FAIL stall_stable: got unstable=%b seen=%b want 0 1", unstable, have);
    else passed++;
    checks++;
    if (tids.size() !== 3) $display("FAIL stall_count: got %0d responses want 3", tids.size());
    else if (tids[0] !== 3'd1 || tids[1] !== 3'd2 || tids[2] !== 3'd3 || rds[0] !== 5'd11 || rds[2] !== 5'd13 ||
             datas[0] !== 32'hdead55ef || datas[1] !== 32'hdead55ef || datas[2] !== 32'hdead55ef)
      $display("FAIL stall_order: got tids %0d %0d %0d rd0=%0d rd2=%0d data %h %h %h want tids 1 2 3 rd 11 13 data dead55ef",
               tids[0], tids[1], tids[2], rds[0], rds[2], datas[0], datas[1], datas[2]);
    else passed++;
  endtask

  task automatic test_illegal();
    rsp_t r;
    int lat;
    logic [31:0] want;
    xact(1, 3'b011, 32'h10, 32'h12345678, 5'd2, 3'd3, r, lat);
    checks++;
    if (r.err !== 1 || r.rdata !== 0 || r.store !== 1) $display("FAIL ill_011: got err=%b rdata=%h store=%b want 1 0 1", r.err, r.rdata, r.store);
    else passed++;
    xact(1, 3'b100, 32'h10, 32'h12345678, 5'd2, 3'd3, r, lat);
    checks++;
    if (r.err !== 1 || r.rdata !== 0) $display("FAIL ill_store_bu: got err=%b rdata=%h want 1 0", r.err, r.rdata);
    else passed++;
    xact(0, 3'b110, 32'h10, 0, 5'd2, 3'd3, r, lat);
    checks++;
    if (r.err !== 1 || r.rdata !== 0) $display("FAIL ill_load_110: got err=%b rdata=%h want 1 0", r.err, r.rdata);
    else passed++;
    xact(0, 3'b010, 32'h10, 0, 5'd2, 3'd3, r, lat);
    checks++;
    if (r.rdata !== 32'hdead55ef) $display("FAIL ill_unchanged: got %h want dead55ef", r.rdata);
    else passed++;
    xact(1, 3'b010, 32'h12, 32'hcafef00d, 5'd2, 3'd3, r, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
    want = 32'hdead55ef;
    checks++;
    if (r.err !== 1) $display("FAIL sw_misaligned: got err=%b want 1", r.err);
    else passed++;
`else
    want = 32'hcafef00d;
    checks++;
    if (r.err !== 0) $display("FAIL sw_misaligned: got err=%b want 0", r.err);
    else passed++;
`endif
    xact(0, 3'b010, 32'h10, 0, 5'd2, 3'd3, r, lat);
    checks++;
    if (r.rdata !== want) $display("FAIL sw_misaligned_readback: got %h want %h", r.rdata, want);
    else passed++;
  endtask

  task automatic test_reset_midstream();
    rsp_t r;
    int lat, seen = 0;
    logic [31:0] want;
`ifdef DMEM_MISALIGN_TRAP_EN
    want = 32'hdead55ef;
`else
    want = 32'hcafef00d;
`endif
    bus.rsp_ready = 0;
    drive(0, 3'b010, 32'h10, 0, 5'd20, 3'd4);
    @(posedge clk);
    #1 drive(0, 3'b010, 32'h10, 0, 5'd21, 3'd5);
    @(posedge clk);
    #1 idle();
    checks++;
    if (bus.rsp_valid !== 1'b1) $display("FAIL midrst_inflight: got valid=%b want 1", bus.rsp_valid);
    else passed++;
    #2 rst_n = 0;
    #1;
    checks++;
    if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_rd, bus.rsp_tid} !== '0)
      $display("FAIL midrst_clear: got valid=%b rdata=%h rd=%0d tid=%0d want 0", bus.rsp_valid, bus.rsp_rdata, bus.rsp_rd, bus.rsp_tid);
    else passed++;
    @(negedge clk);
    rst_n = 1;
    bus.rsp_ready = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    checks++;
    if (seen !== 0 || bus.req_ready !== 1'b1) $display("FAIL midrst_dropped: got %0d responses ready=%b want 0 1", seen, bus.req_ready);
    else passed++;
    @(posedge clk);
    #1 xact(0, 3'b010, 32'h10, 0, 5'd1, 3'd0, r, lat);
    checks++;
    if (r.rdata !== want || lat !== 2) $display("FAIL midrst_retained: got %h lat=%0d want %h 2", r.rdata, lat, want);
    else passed++;
  endtask

  task automatic test_random();
    rsp_t got, held;
    logic hold = 0, fired = 0;
    int sent = 0;
    idle();
    bus.rsp_ready = 1;
    for (int c = 0; c < 700; c++) begin
      if (!bus.req_valid || fired) begin
        if (sent < 16) drive(1, 3'b010, ($urandom & 32'hfffff000) | (32'(sent) << 2), $urandom, 5'($urandom), 3'($urandom));
        else if (c < 550 && $urandom_range(3, 0) != 0)
          drive(1'($urandom), 3'($urandom), ($urandom & 32'hfffff000) | 32'($urandom_range(63, 0)), $urandom, 5'($urandom), 3'($urandom));
        else idle();
      end
      bus.rsp_ready = sent < 16 || c >= 550 || $urandom_range(9, 0) < 7;
      @(negedge clk);
      got = rsp_t'{bus.rsp_rdata, bus.rsp_rd, bus.rsp_tid, bus.rsp_store, bus.rsp_err};
      if (hold) begin
        checks++;
        if (bus.rsp_valid !== 1'b1 || got !== held) $display("FAIL rnd_hold c%0d: got valid=%b %h want 1 %h", c, bus.rsp_valid, got, held);
        else passed++;
      end
      hold = bus.rsp_valid && !bus.rsp_ready;
      held = got;
      if (bus.rsp_valid && bus.rsp_ready) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL rnd_extra c%0d: got unexpected response %h", c, got);
        else if (got !== exp_q[0]) $display("FAIL rnd_rsp c%0d: got %h want %h", c, got, exp_q.pop_front());
        else begin
          void'(exp_q.pop_front());
          passed++;
        end
      end
      fired = bus.req_valid && bus.req_ready;
      if (fired) begin
        exp_q.push_back(model(bus.req_we, bus.req_funct3, bus.req_addr, bus.req_wdata, bus.req_rd, bus.req_tid));
        sent++;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (exp_q.size() != 0 || sent < 100) $display("FAIL rnd_drain: got %0d outstanding after %0d sent want 0", exp_q.size(), sent);
    else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_extend();
    test_store_byte();
    test_stall();
    test_illegal();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
